// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-receive and program-memory write signals of the boot loader.
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   mem_we     program memory write enable, one-cycle pulse per word
//   mem_addr   byte address of the word being written (word aligned)
//   mem_wdata  word being written
// master: the loader (consumes bytes, drives the memory write port).
// slave:  the environment (UART + program RAM).
interface prog_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: serial boot loader. Receives a frame of
//   CNT lo, CNT hi, 4*N data bytes (little-endian words), 8-bit checksum of the data bytes
// and writes each word to program memory at consecutive word-aligned byte addresses.
// The CPU stays in reset until a full image with a matching checksum has arrived.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   bus      prog_loader_if.master (rx byte strobe in, memory write port out)
//   cpu_rst  high = CPU held in reset
//   done     image loaded, checksum correct (sticky until rst)
//   err      image rejected (word count too large or checksum mismatch)
module prog_loader #(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    prog_loader_if.master        bus,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 err
);

    // k must be able to reach MEM_SIZE itself (one past the last word index)
    localparam int unsigned KW = $clog2(MEM_SIZE + 1);

    typedef enum logic [2:0] {
        StCnt0,
        StCnt1,
        StData,
        StSum,
        StDone,
        StErr
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [7:0]    sum_q, sum_d;
    logic [KW-1:0] k_q, k_d;
    logic [1:0]    lane_q, lane_d;
    logic [23:0]   lanes_q, lanes_d;   // bytes b2,b1,b0 of the word in progress
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [15:0]   cnt_full;

    assign cnt_full = {bus.rx_data, n_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StCnt0;
            n_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            lane_q  <= '0;
            lanes_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            lane_q  <= lane_d;
            lanes_q <= lanes_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        sum_d   = sum_q;
        k_d     = k_q;
        lane_d  = lane_q;
        lanes_d = lanes_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            // ERR retries: the next byte starts a new frame exactly like CNT0
            StCnt0, StErr: begin
                if (bus.rx_valid) begin
                    n_d     = {8'h00, bus.rx_data};
                    sum_d   = '0;
                    k_d     = '0;
                    lane_d  = '0;
                    state_d = StCnt1;
                end
            end
            StCnt1: begin
                if (bus.rx_valid) begin
                    n_d = cnt_full;
                    if (32'(cnt_full) > MEM_SIZE) begin
                        state_d = StErr;
                    end else if (cnt_full == 16'd0) begin
                        state_d = StSum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bus.rx_valid) begin
                    sum_d  = sum_q + bus.rx_data;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = 32'({k_q, 2'b00});
                        wdata_d = {bus.rx_data, lanes_q};
                        k_d     = k_q + KW'(1);
                        if (16'(k_q) + 16'd1 == n_q) begin
                            state_d = StSum;
                        end
                    end else begin
                        lanes_d[lane_q*8 +: 8] = bus.rx_data;
                    end
                end
            end
            StSum: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == sum_q) ? StDone : StErr;
                end
            end
            StDone: begin
                // sticky until rst; further bytes are ignored
            end
            default: state_d = StCnt0;
        endcase
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign done          = (state_q == StDone);
    assign err           = (state_q == StErr);
    assign cpu_rst       = ~done;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed frames, write timing, checksum and
// count errors, retry, empty image, mid-frame reset and back-to-back bytes.
module tb_prog_loader;

    logic clk;
    logic rst;
    logic cpu_rst;
    logic done;
    logic err;

    int n_chk;
    int n_pass;
    int wr_count;
    logic [31:0] tb_mem [0:255];

    prog_loader_if bus ();

    prog_loader #(
        .MEM_SIZE(256)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampled 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.mem_we === 1'b1) begin
            wr_count++;
            tb_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one byte for exactly one cycle (negedge to negedge), then optional idle cycles
    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    // Frame: 02 00 | 11 22 33 44 | 55 66 77 88 | cs ; returns right after cs is accepted
    task automatic frame1(input int gap, input logic [7:0] cs, input string tag);
        send(8'h02, gap);
        send(8'h00, gap);
        send(8'h11, gap);
        send(8'h22, gap);
        send(8'h33, gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h44;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check_eq({tag, " w0 we"}, 32'(bus.mem_we), 32'd1);
        check_eq({tag, " w0 addr"}, bus.mem_addr, 32'h0000_0000);
        check_eq({tag, " w0 data"}, bus.mem_wdata, 32'h4433_2211);
        for (int i = 0; i < gap; i++) @(negedge clk);
        send(8'h55, gap);
        if (gap == 0) check_eq({tag, " we one cycle"}, 32'(bus.mem_we), 32'd0);
        send(8'h66, gap);
        send(8'h77, gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h88;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check_eq({tag, " w1 we"}, 32'(bus.mem_we), 32'd1);
        check_eq({tag, " w1 addr"}, bus.mem_addr, 32'h0000_0004);
        check_eq({tag, " w1 data"}, bus.mem_wdata, 32'h8877_6655);
        for (int i = 0; i < gap; i++) @(negedge clk);
        check_eq({tag, " done before cs"}, 32'(done), 32'd0);
        send(cs, 0);
        check_eq({tag, " addr hold"}, bus.mem_addr, 32'h0000_0004);
    endtask

    initial begin
        int wc;
        n_chk        = 0;
        n_pass       = 0;
        wr_count     = 0;
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst we", 32'(bus.mem_we), 32'd0);
        check_eq("rst addr", bus.mem_addr, 32'd0);
        check_eq("rst wdata", bus.mem_wdata, 32'd0);
        check_eq("rst cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: good frame with idle gaps
        frame1(1, 8'h64, "t1");
        check_eq("t1 done", 32'(done), 32'd1);
        check_eq("t1 cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("t1 err", 32'(err), 32'd0);
        check_eq("t1 mem0", tb_mem[0], 32'h4433_2211);
        check_eq("t1 mem1", tb_mem[1], 32'h8877_6655);

        // 2: bad checksum, writes still happen
        do_reset();
        wc = wr_count;
        frame1(1, 8'h65, "t2");
        check_eq("t2 err", 32'(err), 32'd1);
        check_eq("t2 cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("t2 done", 32'(done), 32'd0);
        check_eq("t2 writes", 32'(wr_count - wc), 32'd2);

        // 3: count too large, then retry
        do_reset();
        wc = wr_count;
        send(8'h01, 1);
        send(8'h01, 0);
        check_eq("t3 err", 32'(err), 32'd1);
        check_eq("t3 cpu_rst", 32'(cpu_rst), 32'd1);
        @(negedge clk);
        check_eq("t3 no write", 32'(wr_count - wc), 32'd0);
        send(8'h01, 0);
        check_eq("t3 err clr", 32'(err), 32'd0);
        send(8'h00, 1);
        send(8'hAA, 1);
        send(8'hBB, 1);
        send(8'hCC, 1);
        send(8'hDD, 0);
        check_eq("t3 w addr", bus.mem_addr, 32'h0000_0000);
        check_eq("t3 w data", bus.mem_wdata, 32'hDDCC_BBAA);
        send(8'h0E, 0);
        check_eq("t3 done", 32'(done), 32'd1);
        check_eq("t3 cpu_rst low", 32'(cpu_rst), 32'd0);

        // 4: empty image, later bytes ignored
        do_reset();
        wc = wr_count;
        send(8'h00, 1);
        send(8'h00, 1);
        send(8'h00, 0);
        check_eq("t4 done", 32'(done), 32'd1);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h78, 0);
        send(8'h9A, 2);
        check_eq("t4 no write", 32'(wr_count - wc), 32'd0);
        check_eq("t4 done sticky", 32'(done), 32'd1);
        check_eq("t4 cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("t4 err", 32'(err), 32'd0);

        // 5: reset mid-frame after 6 data bytes
        do_reset();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'h55, 0);
        send(8'h66, 0);
        rst = 1'b1;
        #1;
        check_eq("t5 wdata", bus.mem_wdata, 32'd0);
        check_eq("t5 addr", bus.mem_addr, 32'd0);
        check_eq("t5 cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("t5 we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame1(1, 8'h64, "t5");
        check_eq("t5 done", 32'(done), 32'd1);

        // 6: back-to-back bytes
        do_reset();
        wc = wr_count;
        frame1(0, 8'h64, "t6");
        check_eq("t6 done", 32'(done), 32'd1);
        check_eq("t6 cpu_rst", 32'(cpu_rst), 32'd0);
        check_eq("t6 writes", 32'(wr_count - wc), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
